// File: rtl/hist_pkg.sv
// Shared definitions for the histogram request arbiter: controller state
// encoding and the default geometry used by the arbiter and its helpers.
package hist_pkg;

    localparam int HIST_NREQ_DEF  = 4;
    localparam int HIST_BIN_W_DEF = 6;
    localparam int HIST_CNT_W_DEF = 8;

    // RUN issues grants, DRAIN waits for the output register to empty,
    // HELD reports full quiescence until hold is released.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HELD  = 2'd2
    } hist_state_e;

endpackage

// File: rtl/hist_rr_pick.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// set request bit at or above ptr, wrapping from NREQ-1 back to 0.
module hist_rr_pick
    import hist_pkg::*;
#(
    parameter int NREQ  = HIST_NREQ_DEF,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    logic found;
    int   idx;

    // Walk the requesters starting at ptr and grant the first one found.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hist_req_arbiter.sv
// Round-robin arbiter funnelling per-requester bin-increment requests into a
// single histogram increment port, with a hold/drain quiesce controller and
// saturating per-requester grant counters.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. The upstream side (req_valid/req_ready) and downstream side
// (hist_valid/hist_ready) both follow this rule; valid may drop without a
// transfer on the request side, and hist_bin/hist_src never change while
// hist_valid is high and hist_ready is low.
module hist_req_arbiter
    import hist_pkg::*;
#(
    parameter int  NREQ  = HIST_NREQ_DEF,
    parameter int  BIN_W = HIST_BIN_W_DEF,
    parameter int  CNT_W = HIST_CNT_W_DEF,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*BIN_W-1:0] req_bin,
    output logic [NREQ-1:0]       req_ready,
    output logic                  hist_valid,
    output logic [BIN_W-1:0]      hist_bin,
    output logic [SRC_W-1:0]      hist_src,
    input  logic                  hist_ready,
    input  logic                  hold,
    output logic                  held,
    input  logic [SRC_W-1:0]      cnt_sel,
    output logic [CNT_W-1:0]      cnt_data,
    input  logic                  cnt_clr
);

    hist_state_e      state_q;
    hist_state_e      state_d;
    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] rr_ptr_nxt;
    logic             slot_free;
    logic             grant_en;
    logic [NREQ-1:0]  pick_req;
    logic [NREQ-1:0]  pick_gnt;
    logic             accept;
    logic [SRC_W-1:0] gnt_idx;
    logic [BIN_W-1:0] gnt_bin;
    logic [CNT_W-1:0] cnt_q [NREQ];

    // The output register can take a new entry when it is empty or is being
    // emptied this very cycle; grants also stay off while reset is asserted.
    assign slot_free = !hist_valid || hist_ready;
    assign grant_en  = rst_n && (state_q == RUN) && slot_free;
    assign pick_req  = req_valid & {NREQ{grant_en}};

    hist_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (SRC_W)
    ) u_rr_pick (
        .req (pick_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt)
    );

    assign req_ready = pick_gnt;
    assign accept    = |pick_gnt;
    assign held      = (state_q == HELD);

    // Encode the one-hot grant and select the granted requester's bin.
    always_comb begin
        gnt_idx = '0;
        gnt_bin = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                gnt_idx = SRC_W'(i);
                gnt_bin = req_bin[i*BIN_W +: BIN_W];
            end
        end
    end

    // Pointer moves to the slot just past the winner, wrapping at NREQ.
    always_comb begin
        rr_ptr_nxt = gnt_idx + SRC_W'(1);
        if (int'(gnt_idx) == NREQ - 1) begin
            rr_ptr_nxt = '0;
        end
    end

    // Round-robin pointer register, updated only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= rr_ptr_nxt;
        end
    end

    // Single-entry output register: load on accept, empty on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid <= 1'b0;
            hist_bin   <= '0;
            hist_src   <= '0;
        end else if (accept) begin
            hist_valid <= 1'b1;
            hist_bin   <= gnt_bin;
            hist_src   <= gnt_idx;
        end else if (hist_ready) begin
            hist_valid <= 1'b0;
        end
    end

    // Quiesce controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Quiesce controller next state; releasing hold always returns to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hold) state_d = DRAIN;
            end
            DRAIN: begin
                if (!hold)           state_d = RUN;
                else if (!hist_valid) state_d = HELD;
            end
            HELD: begin
                if (!hold) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Saturating grant counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (accept && (cnt_q[gnt_idx] != {CNT_W{1'b1}})) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
        end
    end

    // Counter read port; out-of-range selects read as zero.
    always_comb begin
        cnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(cnt_sel) == i) cnt_data = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_hist_req_arbiter.sv
// Bench for hist_req_arbiter: a cycle model predicts req_ready, hist_valid,
// held and counter reads every cycle, and a queue of expected {src, bin}
// entries is checked against the output register until it transfers.
module tb_hist_req_arbiter;

  localparam int NREQ  = 4;
  localparam int BIN_W = 6;
  localparam int CNT_W = 8;
  localparam int SRC_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*BIN_W-1:0] req_bin = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  hist_valid;
  logic [BIN_W-1:0]      hist_bin;
  logic [SRC_W-1:0]      hist_src;
  logic                  hist_ready = 1'b0;
  logic                  hold = 1'b0;
  logic                  held;
  logic [SRC_W-1:0]      cnt_sel = '0;
  logic [CNT_W-1:0]      cnt_data;
  logic                  cnt_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [SRC_W+BIN_W-1:0] exp_q[$];

  int         m_ptr = 0;
  logic       m_hv = 1'b0;
  logic [1:0] m_state = 2'd0;
  int         m_cnt [NREQ];

  hist_req_arbiter #(
    .NREQ  (NREQ),
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_bin    (req_bin),
    .req_ready  (req_ready),
    .hist_valid (hist_valid),
    .hist_bin   (hist_bin),
    .hist_src   (hist_src),
    .hist_ready (hist_ready),
    .hold       (hold),
    .held       (held),
    .cnt_sel    (cnt_sel),
    .cnt_data   (cnt_data),
    .cnt_clr    (cnt_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int idx, input logic [BIN_W-1:0] b);
    req_bin[idx*BIN_W +: BIN_W] = b;
  endtask

  // scoreboard and cycle model, evaluated mid-cycle
  always @(negedge clk) begin : scoreboard
    logic [NREQ-1:0]        e_rdy;
    logic [1:0]             nxt;
    logic [SRC_W+BIN_W-1:0] head;
    int                     g;
    int                     idx;
    if (!rst_n) begin
      m_ptr   = 0;
      m_hv    = 1'b0;
      m_state = 2'd0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      exp_q.delete();
      check_eq("rst_hist_valid", 32'(hist_valid), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_held", 32'(held), 32'd0);
      check_eq("rst_cnt_data", 32'(cnt_data), 32'd0);
    end else begin
      g     = -1;
      e_rdy = '0;
      if (m_state == 2'd0 && (!m_hv || hist_ready)) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) e_rdy[g] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
      check_eq("hist_valid", 32'(hist_valid), 32'(m_hv));
      check_eq("held", 32'(held), 32'(m_state == 2'd2));
      check_eq("cnt_data", 32'(cnt_data), 32'(m_cnt[cnt_sel]));
      if (m_hv) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty: got src %0d bin %0d expected no entry at %0t", hist_src, hist_bin, $time);
        end else begin
          head = exp_q[0];
          check_eq("hist_src", 32'(hist_src), 32'(head[SRC_W+BIN_W-1:BIN_W]));
          check_eq("hist_bin", 32'(hist_bin), 32'(head[BIN_W-1:0]));
          if (hist_ready) void'(exp_q.pop_front());
        end
      end
      nxt = m_state;
      case (m_state)
        2'd0: if (hold) nxt = 2'd1;
        2'd1: begin
          if (!hold) nxt = 2'd0;
          else if (!m_hv) nxt = 2'd2;
        end
        default: if (!hold) nxt = 2'd0;
      endcase
      if (g >= 0) begin
        exp_q.push_back({SRC_W'(g), req_bin[g*BIN_W +: BIN_W]});
        m_hv  = 1'b1;
        m_ptr = (g + 1) % NREQ;
      end else if (hist_ready) begin
        m_hv = 1'b0;
      end
      if (cnt_clr) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (g >= 0 && m_cnt[g] < 255) begin
        m_cnt[g] = m_cnt[g] + 1;
      end
      m_state = nxt;
    end
  end

  initial begin
    // reset
    repeat (3) tick();

    // all requesters valid: grants rotate 0,1,2,3,0 and src trails by a cycle
    rst_n      = 1'b1;
    req_valid  = 4'hF;
    hist_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      req_bin = 24'($urandom);
      @(negedge clk);
      check_eq("rot_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) check_eq("rot_src", 32'(hist_src), 32'((k - 1) % 4));
    end

    // single request stalled downstream
    tick();
    req_valid = '0;
    tick();
    req_valid  = 4'b0100;
    set_bin(2, 6'd17);
    hist_ready = 1'b0;
    @(negedge clk);
    check_eq("stall_grant", 32'(req_ready), 32'b0100);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check_eq("stall_valid", 32'(hist_valid), 32'd1);
      check_eq("stall_bin", 32'(hist_bin), 32'd17);
      check_eq("stall_ready", 32'(req_ready), 32'd0);
    end
    tick();
    req_valid  = '0;
    hist_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("stall_done", 32'(hist_valid), 32'd0);

    // hold with a pending entry: drain, then held, then resume
    req_valid  = 4'b0001;
    set_bin(0, 6'($urandom));
    hist_ready = 1'b0;
    tick();
    req_valid = '0;
    hold      = 1'b1;
    @(negedge clk);
    check_eq("hold_run", 32'(held), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      check_eq("hold_drain", 32'(held), 32'd0);
    end
    tick();
    hist_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_drain_xfer", 32'(held), 32'd0);
    tick();
    @(negedge clk);
    check_eq("hold_drain_empty", 32'(held), 32'd0);
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    check_eq("hold_held", 32'(held), 32'd1);
    check_eq("hold_no_grant", 32'(req_ready), 32'd0);
    tick();
    hold = 1'b0;
    @(negedge clk);
    check_eq("release_no_grant", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    check_eq("release_grant", 32'(req_ready), 32'b0010);

    // counter saturation and clear priority
    tick();
    req_valid = 4'b0010;
    cnt_sel   = 2'd1;
    repeat (300) tick();
    @(negedge clk);
    check_eq("cnt_sat", 32'(cnt_data), 32'd255);
    tick();
    cnt_clr = 1'b1;
    @(negedge clk);
    check_eq("clr_grant", 32'(req_ready), 32'b0010);
    tick();
    cnt_clr   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_eq("cnt_clr", 32'(cnt_data), 32'd0);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      tick();
      req_valid  = 4'($urandom_range(0, 15));
      req_bin    = 24'($urandom);
      hist_ready = ($urandom_range(0, 3) != 0);
      cnt_sel    = 2'($urandom_range(0, 3));
      cnt_clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
    end

    // asynchronous reset with an entry pending
    tick();
    hold       = 1'b0;
    cnt_clr    = 1'b0;
    req_valid  = '0;
    hist_ready = 1'b1;
    repeat (2) tick();
    req_valid  = 4'b0100;
    hist_ready = 1'b0;
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(hist_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(hist_valid), 32'd0);
    check_eq("async_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) tick();
    rst_n      = 1'b1;
    req_valid  = 4'b1010;
    hist_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_eq("post_rst_src", 32'(hist_src), 32'd1);
    repeat (3) tick();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
